// File: rtl/xentry_pkg.sv
// Shared memory-subsystem types.
// memory_operation_e : request type the L1 caches drive toward L2
// arb_state_e        : ownership state of the L2 request port
// requester_e        : identifies an L1 requester (used for round-robin)
package xentry_pkg;

    typedef enum logic {
        LOAD  = 1'b0,
        STORE = 1'b1
    } memory_operation_e;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IC   = 2'd1,
        ARB_DC   = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_IC = 1'b0,
        REQ_DC = 1'b1
    } requester_e;

endpackage

// File: rtl/l2_arbiter_sat_counter.sv
// Saturating up-counter.
// clk   : clock
// reset : synchronous active-high clear
// inc   : count one event this cycle
// count : current value, sticks at all-ones
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = (r_count == {WIDTH{1'b1}});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && !w_at_max) begin
            r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign count = r_count;

endmodule

// File: rtl/l2_arbiter.sv
// Two-way arbiter for the single L2 request port (icache vs dcache).
// A grant is held for as long as the owner keeps its req_valid high, so the
// words of a line fill or write-back never interleave with the other cache.
//
// clk, reset                 : clock, synchronous active-high reset
// ic_req_* / dc_req_*        : L1 request (address, type, valid, store word)
// ic_/dc_fetched_word(_valid): L2 response routed back to the owner only
// l2_req_*                   : muxed request toward L2
// l2_fetched_word(_valid)    : L2 response
// ic_/dc_grant_count         : saturating number of grants issued
//
// state    | meaning
// ARB_IDLE | no owner; L2 request driven inactive
// ARB_IC   | icache owns the L2 port
// ARB_DC   | dcache owns the L2 port
module l2_arbiter
    import xentry_pkg::*;
#(
    parameter int   XLEN           = 32,
    parameter int   CNT_WIDTH      = 16,
    parameter logic FIRST_PRIORITY = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic [XLEN-1:0]      ic_req_address,
    input  memory_operation_e    ic_req_type,
    input  logic                 ic_req_valid,
    input  logic [XLEN-1:0]      ic_word_to_store,
    output logic [XLEN-1:0]      ic_fetched_word,
    output logic                 ic_fetched_word_valid,

    input  logic [XLEN-1:0]      dc_req_address,
    input  memory_operation_e    dc_req_type,
    input  logic                 dc_req_valid,
    input  logic [XLEN-1:0]      dc_word_to_store,
    output logic [XLEN-1:0]      dc_fetched_word,
    output logic                 dc_fetched_word_valid,

    output logic [XLEN-1:0]      l2_req_address,
    output memory_operation_e    l2_req_type,
    output logic                 l2_req_valid,
    output logic [XLEN-1:0]      l2_word_to_store,
    input  logic [XLEN-1:0]      l2_fetched_word,
    input  logic                 l2_fetched_word_valid,

    output logic [CNT_WIDTH-1:0] ic_grant_count,
    output logic [CNT_WIDTH-1:0] dc_grant_count
);

    // "Last granted" starts as the requester that should lose the first tie.
    localparam requester_e LAST_AFTER_RESET = FIRST_PRIORITY ? REQ_IC : REQ_DC;

    arb_state_e r_state;
    arb_state_e w_next_state;
    requester_e r_last;
    logic       w_enter_ic;
    logic       w_enter_dc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ARB_IDLE;
            r_last  <= LAST_AFTER_RESET;
        end else begin
            r_state <= w_next_state;
            if (w_enter_ic) begin
                r_last <= REQ_IC;
            end else if (w_enter_dc) begin
                r_last <= REQ_DC;
            end
        end
    end

    always_comb begin
        w_next_state     = r_state;
        l2_req_valid     = 1'b0;
        l2_req_type      = LOAD;
        l2_req_address   = '0;
        l2_word_to_store = '0;
        case (r_state)
            ARB_IDLE: begin
                if (ic_req_valid && dc_req_valid) begin
                    w_next_state = (r_last == REQ_DC) ? ARB_IC : ARB_DC;
                end else if (ic_req_valid) begin
                    w_next_state = ARB_IC;
                end else if (dc_req_valid) begin
                    w_next_state = ARB_DC;
                end
            end
            ARB_IC: begin
                // Dropping valid releases the port; hand over straight away.
                if (!ic_req_valid) begin
                    w_next_state = dc_req_valid ? ARB_DC : ARB_IDLE;
                end
                l2_req_valid     = ic_req_valid;
                l2_req_type      = ic_req_type;
                l2_req_address   = ic_req_address;
                l2_word_to_store = ic_word_to_store;
            end
            ARB_DC: begin
                if (!dc_req_valid) begin
                    w_next_state = ic_req_valid ? ARB_IC : ARB_IDLE;
                end
                l2_req_valid     = dc_req_valid;
                l2_req_type      = dc_req_type;
                l2_req_address   = dc_req_address;
                l2_word_to_store = dc_word_to_store;
            end
            default: begin
                w_next_state = ARB_IDLE;
            end
        endcase
    end

    assign w_enter_ic = (w_next_state == ARB_IC) && (r_state != ARB_IC);
    assign w_enter_dc = (w_next_state == ARB_DC) && (r_state != ARB_DC);

    assign ic_fetched_word       = l2_fetched_word;
    assign dc_fetched_word       = l2_fetched_word;
    assign ic_fetched_word_valid = l2_fetched_word_valid && (r_state == ARB_IC);
    assign dc_fetched_word_valid = l2_fetched_word_valid && (r_state == ARB_DC);

    sat_counter #(.WIDTH(CNT_WIDTH)) u_ic_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_enter_ic),
        .count (ic_grant_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_dc_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_enter_dc),
        .count (dc_grant_count)
    );

endmodule

// File: tb/tb_l2_arbiter.sv
// Scoreboard bench for l2_arbiter. A single-cycle L2 model answers every
// active request in the same cycle; expected L2 requests and per-cache
// responses are queued by the tests and consumed by a monitor.
module tb_l2_arbiter;
    import xentry_pkg::*;

    typedef struct packed {
        logic [31:0]       addr;
        memory_operation_e op;
        logic [31:0]       wdata;
    } l2_exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [31:0]       ic_req_address = '0, dc_req_address = '0;
    memory_operation_e ic_req_type = LOAD, dc_req_type = LOAD;
    logic              ic_req_valid = 1'b0, dc_req_valid = 1'b0;
    logic [31:0]       ic_word_to_store = '0, dc_word_to_store = '0;
    logic [31:0]       ic_fetched_word, dc_fetched_word;
    logic              ic_fetched_word_valid, dc_fetched_word_valid;
    logic [31:0]       l2_req_address;
    memory_operation_e l2_req_type;
    logic              l2_req_valid;
    logic [31:0]       l2_word_to_store;
    logic [31:0]       l2_fetched_word = '0;
    logic              l2_fetched_word_valid = 1'b0;
    logic              l2_force = 1'b0;
    logic [15:0]       ic_grant_count, dc_grant_count;

    logic [31:0]       s_ic_fw, s_dc_fw, s_l2_addr, s_l2_wdata;
    logic              s_ic_fv, s_dc_fv, s_l2_valid;
    memory_operation_e s_l2_type;
    logic [1:0]        s_ic_cnt, s_dc_cnt;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    l2_exp_t     q_l2[$];
    logic [31:0] q_ic[$];
    logic [31:0] q_dc[$];

    l2_arbiter u_dut (
        .clk(clk), .reset(reset),
        .ic_req_address(ic_req_address), .ic_req_type(ic_req_type),
        .ic_req_valid(ic_req_valid), .ic_word_to_store(ic_word_to_store),
        .ic_fetched_word(ic_fetched_word), .ic_fetched_word_valid(ic_fetched_word_valid),
        .dc_req_address(dc_req_address), .dc_req_type(dc_req_type),
        .dc_req_valid(dc_req_valid), .dc_word_to_store(dc_word_to_store),
        .dc_fetched_word(dc_fetched_word), .dc_fetched_word_valid(dc_fetched_word_valid),
        .l2_req_address(l2_req_address), .l2_req_type(l2_req_type),
        .l2_req_valid(l2_req_valid), .l2_word_to_store(l2_word_to_store),
        .l2_fetched_word(l2_fetched_word), .l2_fetched_word_valid(l2_fetched_word_valid),
        .ic_grant_count(ic_grant_count), .dc_grant_count(dc_grant_count)
    );

    l2_arbiter #(.CNT_WIDTH(2)) u_small (
        .clk(clk), .reset(reset),
        .ic_req_address(ic_req_address), .ic_req_type(ic_req_type),
        .ic_req_valid(ic_req_valid), .ic_word_to_store(ic_word_to_store),
        .ic_fetched_word(s_ic_fw), .ic_fetched_word_valid(s_ic_fv),
        .dc_req_address(dc_req_address), .dc_req_type(dc_req_type),
        .dc_req_valid(dc_req_valid), .dc_word_to_store(dc_word_to_store),
        .dc_fetched_word(s_dc_fw), .dc_fetched_word_valid(s_dc_fv),
        .l2_req_address(s_l2_addr), .l2_req_type(s_l2_type),
        .l2_req_valid(s_l2_valid), .l2_word_to_store(s_l2_wdata),
        .l2_fetched_word(l2_fetched_word), .l2_fetched_word_valid(l2_fetched_word_valid),
        .ic_grant_count(s_ic_cnt), .dc_grant_count(s_dc_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] l2_data(input logic [31:0] a);
        return (a == 32'h0000_0100) ? 32'hDEAD_BEEF : {a[15:0], ~a[15:0]};
    endfunction

    // Single-cycle L2: answers whatever request is on the port this cycle.
    always @(negedge clk) begin
        #1;
        l2_fetched_word_valid = l2_req_valid | l2_force;
        l2_fetched_word       = l2_data(l2_req_address);
    end

    // Monitor: every presented request/response must match the next expectation.
    always @(negedge clk) begin
        #3;
        if (l2_req_valid) begin
            checks++;
            if (q_l2.size() == 0) begin
                errors++;
                $display("FAIL l2_req: unexpected request addr=%h", l2_req_address);
            end else begin
                l2_exp_t e;
                e = q_l2.pop_front();
                if (l2_req_address !== e.addr || l2_req_type !== e.op || l2_word_to_store !== e.wdata) begin
                    errors++;
                    $display("FAIL l2_req: got addr=%h type=%0d wdata=%h, want addr=%h type=%0d wdata=%h",
                             l2_req_address, l2_req_type, l2_word_to_store, e.addr, e.op, e.wdata);
                end
            end
        end
        if (ic_fetched_word_valid) begin
            checks++;
            if (q_ic.size() == 0) begin
                errors++;
                $display("FAIL ic_resp: unexpected word=%h", ic_fetched_word);
            end else begin
                logic [31:0] w;
                w = q_ic.pop_front();
                if (ic_fetched_word !== w) begin
                    errors++;
                    $display("FAIL ic_resp: got %h want %h", ic_fetched_word, w);
                end
            end
        end
        if (dc_fetched_word_valid) begin
            checks++;
            if (q_dc.size() == 0) begin
                errors++;
                $display("FAIL dc_resp: unexpected word=%h", dc_fetched_word);
            end else begin
                logic [31:0] w;
                w = q_dc.pop_front();
                if (dc_fetched_word !== w) begin
                    errors++;
                    $display("FAIL dc_resp: got %h want %h", dc_fetched_word, w);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit is_dc, input logic v, input logic [31:0] a, input memory_operation_e op);
        if (is_dc) begin
            dc_req_valid = v; dc_req_address = a; dc_req_type = op; dc_word_to_store = ~a;
        end else begin
            ic_req_valid = v; ic_req_address = a; ic_req_type = op; ic_word_to_store = ~a;
        end
    endtask

    task automatic expect_txn(input bit is_dc, input logic [31:0] a, input memory_operation_e op);
        q_l2.push_back('{addr: a, op: op, wdata: ~a});
        if (is_dc) q_dc.push_back(l2_data(a));
        else       q_ic.push_back(l2_data(a));
    endtask

    // Requester model; called and returns at posedge+1.
    task automatic txn(input bit is_dc, input logic [31:0] base, input int ntxn, input int nwords,
                       input memory_operation_e op, input int delay,
                       output int t_raise, output int t_first, output int t_last);
        t_raise = -1; t_first = -1; t_last = -1;
        repeat (delay) begin @(posedge clk); #1; end
        for (int t = 0; t < ntxn; t++) begin
            for (int w = 0; w < nwords; w++) begin
                bit got;
                drive(is_dc, 1'b1, base + 32'(4 * (t * nwords + w)), op);
                if (t == 0 && w == 0) t_raise = cyc;
                got = 1'b0;
                for (int k = 0; k < 300; k++) begin
                    @(negedge clk); #3;
                    if (is_dc ? dc_fetched_word_valid : ic_fetched_word_valid) begin
                        got = 1'b1;
                        break;
                    end
                end
                if (!got) begin
                    checks++; errors++;
                    $display("FAIL %s_wait: no response within 300 cycles, want one", is_dc ? "dc" : "ic");
                    drive(is_dc, 1'b0, '0, LOAD);
                    return;
                end
                if (t_first < 0) t_first = cyc;
                t_last = cyc;
                @(posedge clk); #1;
            end
            drive(is_dc, 1'b0, '0, LOAD);
            if (t != ntxn - 1) begin @(posedge clk); #1; end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, '0, LOAD);
        drive(1'b1, 1'b0, '0, LOAD);
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
    endtask

    task automatic settle(input string name);
        repeat (3) begin @(posedge clk); #1; end
        check({name, "_queues_empty"}, 64'(q_l2.size() + q_ic.size() + q_dc.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int ic_r, ic_f, ic_l, dc_r, dc_f, dc_l;
        @(posedge clk); #1;
        do_reset();

        // Reset state
        @(negedge clk); #3;
        check("rst_l2_valid", 64'(l2_req_valid), 64'd0);
        check("rst_ic_cnt", 64'(ic_grant_count), 64'd0);
        check("rst_dc_cnt", 64'(dc_grant_count), 64'd0);
        check("rst_fv", 64'({ic_fetched_word_valid, dc_fetched_word_valid}), 64'd0);
        @(posedge clk); #1;

        // Single dcache load
        expect_txn(1'b1, 32'h100, LOAD);
        txn(1'b1, 32'h100, 1, 1, LOAD, 0, dc_r, dc_f, dc_l);
        check("t1_latency", 64'(dc_f - dc_r), 64'd1);
        check("t1_dc_cnt", 64'(dc_grant_count), 64'd1);
        check("t1_ic_cnt", 64'(ic_grant_count), 64'd0);
        settle("t1");

        // Simultaneous first requests: dcache wins, icache follows with no bubble
        do_reset();
        expect_txn(1'b1, 32'h300, STORE);
        expect_txn(1'b0, 32'h400, LOAD);
        fork
            txn(1'b1, 32'h300, 1, 1, STORE, 0, dc_r, dc_f, dc_l);
            txn(1'b0, 32'h400, 1, 1, LOAD, 0, ic_r, ic_f, ic_l);
        join
        check("t2_dc_first", 64'(dc_f - dc_r), 64'd1);
        check("t2_ic_handover", 64'(ic_f - dc_l), 64'd2);
        check("t2_ic_cnt", 64'(ic_grant_count), 64'd1);
        check("t2_dc_cnt", 64'(dc_grant_count), 64'd1);
        settle("t2");

        // dcache 4-word fill, icache requests mid-fill
        do_reset();
        for (int i = 0; i < 4; i++) expect_txn(1'b1, 32'h200 + 32'(4 * i), LOAD);
        expect_txn(1'b0, 32'h500, LOAD);
        fork
            txn(1'b1, 32'h200, 1, 4, LOAD, 0, dc_r, dc_f, dc_l);
            txn(1'b0, 32'h500, 1, 1, LOAD, 2, ic_r, ic_f, ic_l);
        join
        check("t3_fill_len", 64'(dc_l - dc_f), 64'd3);
        check("t3_ic_after_fill", 64'(ic_f - dc_l), 64'd2);
        settle("t3");

        // 100 back-to-back grants with both caches continuously requesting
        do_reset();
        for (int i = 0; i < 50; i++) begin
            expect_txn(1'b1, 32'h1000 + 32'(4 * i), LOAD);
            expect_txn(1'b0, 32'h2000 + 32'(4 * i), STORE);
        end
        fork
            txn(1'b1, 32'h1000, 50, 1, LOAD, 0, dc_r, dc_f, dc_l);
            txn(1'b0, 32'h2000, 50, 1, STORE, 0, ic_r, ic_f, ic_l);
        join
        check("t4_ic_cnt", 64'(ic_grant_count), 64'd50);
        check("t4_dc_cnt", 64'(dc_grant_count), 64'd50);
        check("t4_span", 64'(ic_l - dc_f), 64'd198);
        settle("t4");

        // Reset while dcache owns the port and L2 is returning data
        do_reset();
        expect_txn(1'b1, 32'h600, LOAD);
        drive(1'b1, 1'b1, 32'h600, LOAD);
        @(posedge clk); #1;
        l2_force = 1'b1;
        @(negedge clk); #3;
        check("t5_dc_fv_before", 64'(dc_fetched_word_valid), 64'd1);
        check("t5_dc_cnt_before", 64'(dc_grant_count), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); #3;
        check("t5_l2_valid", 64'(l2_req_valid), 64'd0);
        check("t5_dc_fv", 64'(dc_fetched_word_valid), 64'd0);
        check("t5_ic_fv", 64'(ic_fetched_word_valid), 64'd0);
        check("t5_dc_cnt", 64'(dc_grant_count), 64'd0);
        check("t5_ic_cnt", 64'(ic_grant_count), 64'd0);
        @(posedge clk); #1;
        l2_force = 1'b0;
        drive(1'b1, 1'b0, '0, LOAD);
        reset = 1'b0;
        settle("t5");

        // Counter saturation on the 2-bit instance
        do_reset();
        for (int i = 0; i < 5; i++) expect_txn(1'b0, 32'h700 + 32'(4 * i), LOAD);
        txn(1'b0, 32'h700, 5, 1, LOAD, 0, ic_r, ic_f, ic_l);
        check("t6_small_ic_cnt", 64'(s_ic_cnt), 64'd3);
        check("t6_small_dc_cnt", 64'(s_dc_cnt), 64'd0);
        check("t6_wide_ic_cnt", 64'(ic_grant_count), 64'd5);
        settle("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/l2_arbiter.md
# l2_arbiter

Shares the single L2/memory request port between the instruction cache and the data cache. Each cache presents the same request interface the dcache already drives toward L2 (address, type, valid, store word; fetched word and valid back). The arbiter locks a grant for a whole transaction, such as a multi-word line fill or a write-back, so that words from different caches never interleave. It sits between the two L1 caches and the L2 in the memory subsystem.

## Interface
- XLEN, 32, address/data width in bits
- CNT_WIDTH, 16, width of each saturating grant counter
- FIRST_PRIORITY, 1, requester that wins a simultaneous request immediately after reset (1 = dcache, 0 = icache)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- ic_req_address  in  XLEN  icache request address
- ic_req_type  in  memory_operation_e  LOAD/STORE
- ic_req_valid  in  1  icache request; held high for the whole transaction
- ic_word_to_store  in  XLEN  icache store data
- ic_fetched_word  out  XLEN  response word to icache
- ic_fetched_word_valid  out  1  response valid to icache
- dc_*  same six signals for the dcache
- l2_req_address  out  XLEN  muxed address
- l2_req_type  out  memory_operation_e  muxed type
- l2_req_valid  out  1  muxed valid
- l2_word_to_store  out  XLEN  muxed store data
- l2_fetched_word  in  XLEN  L2 response word
- l2_fetched_word_valid  in  1  L2 response valid (load data ready or store done)
- ic_grant_count, dc_grant_count  out  CNT_WIDTH  number of grants issued, saturating

## Operation
- State machine with three states: ARB_IDLE, ARB_IC, ARB_DC.
- ARB_IDLE:
  - Only one valid: go to that requester's state.
  - Both valid: grant the requester not granted last (round-robin). After reset, "last granted" is the complement of FIRST_PRIORITY.
  - Neither valid: stay in ARB_IDLE.
- ARB_IC / ARB_DC:
  - Stay while the owner's valid is high. Address and type may change between words; the grant stays held.
  - Owner's valid low and the other requester's valid high: move directly to the other state, with no idle bubble.
  - Owner's valid low and the other requester idle: return to ARB_IDLE.
- Request mux:
  - The l2_req_* outputs are combinational copies of the owner's signals.
  - In ARB_IDLE: l2_req_valid = 0, l2_req_type = LOAD, address and store word = 0.
- Response routing:
  - l2_fetched_word is copied to both ic_fetched_word and dc_fetched_word.
  - <x>_fetched_word_valid = l2_fetched_word_valid AND (state is that requester's state). The non-owner always sees 0.
- Counters:
  - Increment the matching counter on each edge that enters ARB_IC or ARB_DC, including a direct handover.
  - Each counter saturates at 2^CNT_WIDTH−1.
- Reset:
  - At the first edge with reset high: state = ARB_IDLE, counters = 0, round-robin pointer restored.
  - All fetched_word_valid outputs and l2_req_valid are 0 from that edge on, including when reset lands mid-transaction.
  - Any in-flight L2 response is dropped. Requesters are reset by the same signal.

## Timing
- Arbitration latency is 1 cycle: valid rises in cycle N (state ARB_IDLE), and l2_req_valid is high in cycle N+1.
- The request and response paths add no latency; they are combinational through the registered state.
- Release: the owner drops valid in cycle M, so l2_req_valid is 0 in cycle M. The next owner is driven in cycle M+1.
- Worst-case wait for a requester is one full transaction of the other requester plus 1 cycle.
- A requester must not drop valid and re-raise it in the same cycle to keep the grant. A drop of at least one cycle is a release.

## Structure
- Add to xentry_pkg:
  - arb_state_e {ARB_IDLE, ARB_IC, ARB_DC}
  - requester_e {REQ_IC, REQ_DC}
- Reuse the existing memory_operation_e.
- One sub-module, sat_counter (parameter WIDTH; inputs clk, reset, inc; output count), instantiated twice.

## Test plan
- Single dcache LOAD to 0x0000_0100, L2 returns 0xDEAD_BEEF:
  - l2_req_valid is high 1 cycle after dc_req_valid.
  - dc_fetched_word_valid = 1 with 0xDEAD_BEEF.
  - ic_fetched_word_valid stays 0.
  - dc_grant_count = 1.
- Simultaneous first requests from both caches after reset (FIRST_PRIORITY=1):
  - dcache is granted first.
  - icache is granted in the cycle after dc_req_valid drops, with no idle cycle.
  - Both counts = 1.
- dcache 4-word line fill (addresses 0x200, 0x204, 0x208, 0x20C) while icache requests mid-fill:
  - All four L2 addresses come from the dcache, in order.
  - icache is granted only after the fill completes.
- 100 back-to-back requests with both caches continuously requesting:
  - Grants alternate IC/DC.
  - Counts differ by at most 1.
- reset asserted while in ARB_DC with L2 valid high:
  - Next cycle: state ARB_IDLE, l2_req_valid = 0, dc_fetched_word_valid = 0, counts = 0.
- CNT_WIDTH=2 with 5 icache grants:
  - ic_grant_count saturates at 3.
